// File: rtl/keypad_pkg.sv
// Shared types and helpers for the hex keypad entry block: FSM states,
// row reset pattern and the one-hot-low decoder used for row/column indices.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_ACCEPT   = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    localparam logic [3:0] ROW_RESET = 4'b1110;
    localparam logic [3:0] ALL_ONES  = 4'b1111;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } low_idx_t;

    // True when the vector has exactly one zero bit.
    function automatic logic one_low_valid(input logic [3:0] vec);
        logic res;
        case (vec)
            4'b1110: res = 1'b1;
            4'b1101: res = 1'b1;
            4'b1011: res = 1'b1;
            4'b0111: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Index of the single low bit; valid is cleared for zero or several lows.
    function automatic low_idx_t low_index(input logic [3:0] vec);
        low_idx_t res;
        res.valid = one_low_valid(vec);
        case (vec)
            4'b1110: res.idx = 2'd0;
            4'b1101: res.idx = 2'd1;
            4'b1011: res.idx = 2'd2;
            4'b0111: res.idx = 2'd3;
            default: res.idx = 2'd0;
        endcase
        return res;
    endfunction

    // Advance the active-low row strobe to the next row (row 3 wraps to row 0).
    function automatic logic [3:0] rotate_row(input logic [3:0] row_in);
        return {row_in[2:0], row_in[3]};
    endfunction

endpackage

// File: rtl/hex_keypad_entry_if.sv
// Bus bundle between the keypad entry block and its environment: scan tick,
// keypad columns and clear in; row drive, key event and entry value out.
interface hex_keypad_entry_if;
    logic        tc_scan;
    logic [3:0]  col;
    logic        clear;
    logic [3:0]  row;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] value;
    logic        busy;

    modport master (
        output tc_scan, col, clear,
        input  row, key_valid, key_code, value, busy
    );

    modport slave (
        input  tc_scan, col, clear,
        output row, key_valid, key_code, value, busy
    );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs; resets to a configurable
// idle pattern so released keypad columns read as all ones after reset.
module sync2 #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture of the asynchronous input into the clk domain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/hex_keypad_entry.sv
// Hex keypad scanner: strobes one row at a time, debounces a single key,
// encodes it as 4*row+col and shifts each accepted digit into a 32-bit entry.
module hex_keypad_entry
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic              clk,
    input  logic              reset,
    hex_keypad_entry_if.slave bus
);
    localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_TICKS);

    logic [3:0]  w_col_s;
    logic        w_col_any_low;
    logic        w_col_one_low;
    logic        w_cand_ok;
    logic [3:0]  w_cnt_inc;
    logic [3:0]  w_new_code;
    low_idx_t    w_row_info;
    low_idx_t    w_cand_info;

    kp_state_e   r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_cand;
    logic [3:0]  r_row;
    logic        r_key_valid;
    logic [3:0]  r_key_code;
    logic [31:0] r_value;
    logic        r_busy;

    sync2 #(
        .WIDTH     (4),
        .RESET_VAL (4'b1111)
    ) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.col),
        .o_q   (w_col_s)
    );

    assign w_row_info    = low_index(r_row);
    assign w_cand_info   = low_index(r_cand);
    assign w_col_any_low = (w_col_s != ALL_ONES);
    assign w_col_one_low = one_low_valid(w_col_s) && w_row_info.valid;
    assign w_cand_ok     = w_cand_info.valid && w_row_info.valid;
    assign w_new_code    = {w_row_info.idx, w_cand_info.idx};
    assign w_cnt_inc     = r_cnt + 4'd1;

    // Scan/debounce/accept/release FSM with all outputs held in registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_SCAN;
            r_cnt       <= 4'd0;
            r_cand      <= ALL_ONES;
            r_row       <= ROW_RESET;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
            r_value     <= 32'd0;
            r_busy      <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                ST_SCAN: begin
                    if (bus.tc_scan) begin
                        if (!w_col_any_low) begin
                            r_row <= rotate_row(r_row);
                        end else begin
                            // Row stays put so the pressed key keeps driving its column.
                            r_cand <= w_col_s;
                            r_busy <= 1'b1;
                            if (DB_LIMIT == 4'd1) begin
                                r_cnt   <= 4'd0;
                                r_state <= w_col_one_low ? ST_ACCEPT : ST_RELEASE;
                            end else begin
                                r_cnt   <= 4'd1;
                                r_state <= ST_DEBOUNCE;
                            end
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (bus.tc_scan) begin
                        if (w_col_s == r_cand) begin
                            if (w_cnt_inc == DB_LIMIT) begin
                                // Several lows means ghosting or multi-key: wait it out unaccepted.
                                r_cnt   <= 4'd0;
                                r_state <= w_cand_ok ? ST_ACCEPT : ST_RELEASE;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else if (!w_col_any_low) begin
                            // Bounced open: resume scanning on the same row.
                            r_cnt   <= 4'd0;
                            r_state <= ST_SCAN;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cand <= w_col_s;
                            if (DB_LIMIT == 4'd1) begin
                                r_cnt   <= 4'd0;
                                r_state <= w_col_one_low ? ST_ACCEPT : ST_RELEASE;
                            end else begin
                                r_cnt <= 4'd1;
                            end
                        end
                    end
                end
                ST_ACCEPT: begin
                    r_key_valid <= 1'b1;
                    r_key_code  <= w_new_code;
                    r_value     <= {r_value[27:0], w_new_code};
                    r_cnt       <= 4'd0;
                    r_state     <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (bus.tc_scan) begin
                        if (!w_col_any_low) begin
                            if (w_cnt_inc == DB_LIMIT) begin
                                r_cnt   <= 4'd0;
                                r_row   <= rotate_row(r_row);
                                r_state <= ST_SCAN;
                                r_busy  <= 1'b0;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt <= 4'd0;
                        end
                    end
                end
                default: begin
                    r_cnt   <= 4'd0;
                    r_state <= ST_SCAN;
                    r_busy  <= 1'b0;
                end
            endcase
            // Clear overrides any shift into the entry, including one in ACCEPT.
            if (bus.clear) begin
                r_value <= 32'd0;
            end
        end
    end

    assign bus.row       = r_row;
    assign bus.key_valid = r_key_valid;
    assign bus.key_code  = r_key_code;
    assign bus.value     = r_value;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_hex_keypad_entry.sv
// Scoreboard bench for hex_keypad_entry: a keypad matrix model drives the
// columns, stimulus tasks predict each accepted key and a monitor checks pulses.
`timescale 1ns/1ps
module tb_hex_keypad_entry;
    import keypad_pkg::*;

    localparam int D = 4;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] value;
        int          tick;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] keys_down;
    logic [3:0]  col_drive;
    logic [31:0] model_value;
    int          total = 0;
    int          bad = 0;
    int          tick_cnt = 0;
    int          div = 0;
    exp_t        sb[$];
    exp_t        mon_e;

    hex_keypad_entry_if kif();

    hex_keypad_entry #(.DEBOUNCE_TICKS(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (kif)
    );

    always #5 clk = ~clk;

    // Passive matrix: a held key pulls its column low while its row is driven low.
    always_comb begin
        col_drive = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (kif.row[r] == 1'b0 && keys_down[4*r+c]) col_drive[c] = 1'b0;
            end
        end
    end
    assign kif.col = col_drive;

    // Scan prescaler: one-clk tick every 8 clocks.
    initial begin
        kif.tc_scan = 1'b0;
        forever begin
            @(negedge clk);
            div = (div == 7) ? 0 : div + 1;
            kif.tc_scan = (div == 7);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (kif.tc_scan === 1'b1) tick_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every key_valid pulse must match the oldest predicted key.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && kif.key_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got code %h value %h, expected no pulse", kif.key_code, kif.value);
                end else begin
                    mon_e = sb.pop_front();
                    chk("key_code", {28'd0, kif.key_code}, {28'd0, mon_e.code});
                    chk("value", kif.value, mon_e.value);
                    chk("pulse_tick", tick_cnt, mon_e.tick);
                end
            end
        end
    end

    function automatic logic [3:0] row_of(input int r);
        logic [3:0] v;
        v = 4'b0001 << r;
        return ~v;
    endfunction

    task automatic wait_tick();
        int n = 0;
        @(posedge clk);
        while (kif.tc_scan !== 1'b1 && n < 64) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    // Wait until the scanner has just strobed row r while idle.
    task automatic align_row(input int r, output int n);
        int k = 0;
        do begin
            wait_tick();
            k++;
        end while ((kif.row !== row_of(r) || kif.busy !== 1'b0) && k < 12);
        chk("align_row", {28'd0, kif.row}, {28'd0, row_of(r)});
        n = tick_cnt;
    endtask

    task automatic release_keys(input int r);
        int k = 0;
        int m;
        wait_tick();
        keys_down = 16'h0000;
        m = tick_cnt;
        while (kif.busy !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("busy_drop", {31'd0, kif.busy}, 32'd0);
        chk("release_tick", tick_cnt, m + D);
        chk("row_after_release", {28'd0, kif.row}, {28'd0, row_of((r + 1) % 4)});
    endtask

    task automatic enter_key(input int code, input bit with_clear);
        int n;
        int r = code / 4;
        align_row(r, n);
        keys_down = 16'h0000;
        keys_down[code] = 1'b1;
        model_value = with_clear ? 32'd0 : ((model_value << 4) | 32'(code));
        sb.push_back('{4'(code), model_value, n + D});
        repeat (D) wait_tick();
        if (with_clear) kif.clear = 1'b1;
        @(negedge clk);
        kif.clear = 1'b0;
        release_keys(r);
    endtask

    task automatic do_clear();
        kif.clear = 1'b1;
        @(negedge clk);
        kif.clear = 1'b0;
        model_value = 32'd0;
        chk("clear_value", kif.value, 32'd0);
    endtask

    initial begin
        int n;
        int code;
        reset = 1'b0;
        kif.clear = 1'b0;
        keys_down = 16'h0000;
        model_value = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_row", {28'd0, kif.row}, 32'h0000000E);
        chk("rst_key_valid", {31'd0, kif.key_valid}, 32'd0);
        chk("rst_key_code", {28'd0, kif.key_code}, 32'd0);
        chk("rst_value", kif.value, 32'd0);
        chk("rst_busy", {31'd0, kif.busy}, 32'd0);
        reset = 1'b1;

        // Clean press of key A on row 2.
        enter_key(10, 1'b0);

        // Bounce on key 1: pressed one tick, open one tick, then held.
        align_row(0, n);
        keys_down = 16'h0002;
        wait_tick();
        keys_down = 16'h0000;
        wait_tick();
        keys_down = 16'h0002;
        model_value = (model_value << 4) | 32'd1;
        sb.push_back('{4'h1, model_value, n + 2 + D});
        repeat (D) wait_tick();
        @(negedge clk);
        release_keys(0);

        // Multi-digit entry with overflow on the ninth digit.
        do_clear();
        for (int k = 1; k <= 9; k++) begin
            enter_key(k, 1'b0);
            if (k == 8) chk("eight_digits", kif.value, 32'h12345678);
        end
        chk("nine_digits", kif.value, 32'h23456789);

        // Ghost: two keys on row 1 must never be accepted.
        align_row(1, n);
        keys_down = 16'h0090;
        repeat (D + 2) wait_tick();
        chk("ghost_busy", {31'd0, kif.busy}, 32'd1);
        release_keys(1);

        // Clear landing in the ACCEPT cycle of key F.
        do_clear();
        enter_key(1, 1'b0);
        enter_key(2, 1'b0);
        chk("pre_clear_value", kif.value, 32'h00000012);
        enter_key(15, 1'b1);
        chk("clear_collision_value", kif.value, 32'd0);

        // Reset mid-debounce on key 5; the held key is re-debounced from scratch.
        align_row(1, n);
        keys_down = 16'h0020;
        wait_tick();
        wait_tick();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_row", {28'd0, kif.row}, 32'h0000000E);
        chk("midrst_busy", {31'd0, kif.busy}, 32'd0);
        chk("midrst_value", kif.value, 32'd0);
        model_value = 32'd5;
        sb.push_back('{4'h5, model_value, n + 3 + D});
        repeat (D + 1) wait_tick();
        @(negedge clk);
        release_keys(1);

        // Random keys against the shift-entry model.
        for (int k = 0; k < 6; k++) begin
            code = int'($urandom_range(0, 15));
            enter_key(code, 1'b0);
        end

        repeat (3) wait_tick();
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
